// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG LED multiplexer / ADC sampler.
package ppg_pkg;

    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int ADC_W = 8;

    localparam logic [DC_W-1:0]  DC_IDLE = 7'd64;
    localparam logic [ADC_W-1:0] CLIP_LO = 8'h00;
    localparam logic [ADC_W-1:0] CLIP_HI = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE_IR,
        ST_ACQ_IR,
        ST_SETTLE_RED,
        ST_ACQ_RED,
        ST_SETTLE_DARK,
        ST_ACQ_DARK,
        ST_PRESENT
    } ppg_state_e;

    function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

endpackage

// File: rtl/ppg_chan_avg.sv
// Per-phase ADC averager: accumulates 2^AVG_LOG2 accepted samples and tracks clipping.
module ppg_chan_avg
    import ppg_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             acq,
    input  logic             clip_en,
    input  logic [ADC_W-1:0] adc,
    input  logic             adc_valid,
    output logic             done,
    output logic [ADC_W-1:0] avg,
    output logic             clip
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_q;
    logic             clip_q;
    logic             take;
    logic             hit;

    assign take = acq && adc_valid;
    assign hit  = take && clip_en && (adc == CLIP_LO || adc == CLIP_HI);
    assign sum  = acc_q + ACC_W'(adc);

    // The sample arriving with the final count is folded in combinationally,
    // so the caller stores avg on the same edge that done is seen.
    assign done = take && (cnt_q == CNT_W'(N - 1));
    assign avg  = sum[AVG_LOG2 +: ADC_W];
    assign clip = clip_q | hit;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n || clear) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            clip_q <= 1'b0;
        end else if (take) begin
            acc_q  <= sum;
            cnt_q  <= cnt_q + 1'b1;
            clip_q <= clip_q | hit;
        end
    end

endmodule

// File: rtl/ppg_mux_sampler.sv
// IR/RED LED time-multiplexer with settling, ADC averaging and a valid/ready pair output.
// Optional ambient (dark) subtraction phase is built when PPG_DARK_SUB_EN is defined.
module ppg_mux_sampler
    import ppg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 2,
    parameter int DARK_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DC_W-1:0]  dc_ir,
    input  logic [DC_W-1:0]  dc_red,
    input  logic [PGA_W-1:0] pga_ir,
    input  logic [PGA_W-1:0] pga_red,
    input  logic [ADC_W-1:0] adc,
    input  logic             adc_valid,
    output logic             led_ir,
    output logic             led_red,
    output logic [DC_W-1:0]  dc_comp,
    output logic [PGA_W-1:0] pga_gain,
    output logic [ADC_W-1:0] ir_sample,
    output logic [ADC_W-1:0] red_sample,
    output logic             clip_ir,
    output logic             clip_red,
    output logic             sample_valid,
    input  logic             sample_ready
);

`ifdef PPG_DARK_SUB_EN
    localparam bit DARK_EN = 1'b1;
`else
    localparam bit DARK_EN = 1'b0;
`endif

    localparam int CNT_W = 16;

    ppg_state_e       state_q, state_d;
    logic [CNT_W-1:0] settle_cnt;
    logic             settling;
    logic             settle_done;

    logic [DC_W-1:0]  dc_ir_q, dc_red_q;
    logic [PGA_W-1:0] pga_ir_q, pga_red_q;
    logic [ADC_W-1:0] ir_avg_q, red_avg_q;
    logic             clip_ir_q, clip_red_q;

    logic             acq;
    logic             clip_en;
    logic             chan_done;
    logic [ADC_W-1:0] chan_avg;
    logic             chan_clip;

    assign settling = (state_q == ST_SETTLE_IR) || (state_q == ST_SETTLE_RED) ||
                      (state_q == ST_SETTLE_DARK);
    assign settle_done = (state_q == ST_SETTLE_DARK) ? (settle_cnt == CNT_W'(DARK_CYCLES - 1))
                                                     : (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign acq     = (state_q == ST_ACQ_IR) || (state_q == ST_ACQ_RED) || (state_q == ST_ACQ_DARK);
    assign clip_en = (state_q != ST_ACQ_DARK);

    ppg_chan_avg #(.AVG_LOG2(AVG_LOG2)) u_chan_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!acq || !run),
        .acq       (acq),
        .clip_en   (clip_en),
        .adc       (adc),
        .adc_valid (adc_valid),
        .done      (chan_done),
        .avg       (chan_avg),
        .clip      (chan_clip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d      = state_q;
        led_ir       = 1'b0;
        led_red      = 1'b0;
        dc_comp      = DC_IDLE;
        pga_gain     = '0;
        sample_valid = 1'b0;
        if (state_q != ST_IDLE && !run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (run) state_d = ST_SETTLE_IR;
                ST_SETTLE_IR: begin
                    led_ir   = 1'b1;
                    dc_comp  = dc_ir_q;
                    pga_gain = pga_ir_q;
                    if (settle_done) state_d = ST_ACQ_IR;
                end
                ST_ACQ_IR: begin
                    led_ir   = 1'b1;
                    dc_comp  = dc_ir_q;
                    pga_gain = pga_ir_q;
                    if (chan_done) state_d = ST_SETTLE_RED;
                end
                ST_SETTLE_RED: begin
                    led_red  = 1'b1;
                    dc_comp  = dc_red_q;
                    pga_gain = pga_red_q;
                    if (settle_done) state_d = ST_ACQ_RED;
                end
                ST_ACQ_RED: begin
                    led_red  = 1'b1;
                    dc_comp  = dc_red_q;
                    pga_gain = pga_red_q;
                    if (chan_done) state_d = DARK_EN ? ST_SETTLE_DARK : ST_PRESENT;
                end
                ST_SETTLE_DARK: begin
                    dc_comp  = dc_ir_q;
                    pga_gain = pga_ir_q;
                    if (settle_done) state_d = ST_ACQ_DARK;
                end
                ST_ACQ_DARK: begin
                    dc_comp  = dc_ir_q;
                    pga_gain = pga_ir_q;
                    if (chan_done) state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    sample_valid = 1'b1;
                    if (sample_ready) state_d = ST_SETTLE_IR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !settling || settle_done || !run) settle_cnt <= '0;
        else                                             settle_cnt <= settle_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dc_ir_q    <= '0;
            dc_red_q   <= '0;
            pga_ir_q   <= '0;
            pga_red_q  <= '0;
            ir_avg_q   <= '0;
            red_avg_q  <= '0;
            clip_ir_q  <= 1'b0;
            clip_red_q <= 1'b0;
            ir_sample  <= '0;
            red_sample <= '0;
            clip_ir    <= 1'b0;
            clip_red   <= 1'b0;
        end else if (!run) begin
            clip_ir_q  <= 1'b0;
            clip_red_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dc_ir_q   <= dc_ir;
                    dc_red_q  <= dc_red;
                    pga_ir_q  <= pga_ir;
                    pga_red_q <= pga_red;
                end
                ST_ACQ_IR: if (chan_done) begin
                    ir_avg_q  <= chan_avg;
                    clip_ir_q <= chan_clip;
                end
                ST_ACQ_RED: if (chan_done) begin
                    red_avg_q  <= chan_avg;
                    clip_red_q <= chan_clip;
                    if (!DARK_EN) begin
                        ir_sample  <= ir_avg_q;
                        red_sample <= chan_avg;
                        clip_ir    <= clip_ir_q;
                        clip_red   <= chan_clip;
                    end
                end
                ST_ACQ_DARK: if (chan_done) begin
                    ir_sample  <= sat_sub(ir_avg_q, chan_avg);
                    red_sample <= sat_sub(red_avg_q, chan_avg);
                    clip_ir    <= clip_ir_q;
                    clip_red   <= clip_red_q;
                end
                ST_PRESENT: if (sample_ready) begin
                    clip_ir_q  <= 1'b0;
                    clip_red_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppg_mux_sampler.sv
// Directed self-checking bench for ppg_mux_sampler (default parameters).
module tb_ppg_mux_sampler;

`ifdef PPG_DARK_SUB_EN
    localparam bit DARK = 1'b1;
`else
    localparam bit DARK = 1'b0;
`endif
    localparam logic [7:0] DARK_LVL = 8'd20;

    logic       clk = 1'b0;
    logic       rst_n, run, adc_valid, sample_ready;
    logic [6:0] dc_ir, dc_red, dc_comp;
    logic [3:0] pga_ir, pga_red, pga_gain;
    logic [7:0] adc, ir_sample, red_sample;
    logic       led_ir, led_red, clip_ir, clip_red, sample_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] e_dc_ir, e_dc_red;
    logic [3:0] e_pga_ir, e_pga_red;

    always #5 clk = ~clk;

    ppg_mux_sampler dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .dc_ir(dc_ir), .dc_red(dc_red), .pga_ir(pga_ir), .pga_red(pga_red),
        .adc(adc), .adc_valid(adc_valid),
        .led_ir(led_ir), .led_red(led_red), .dc_comp(dc_comp), .pga_gain(pga_gain),
        .ir_sample(ir_sample), .red_sample(red_sample),
        .clip_ir(clip_ir), .clip_red(clip_red),
        .sample_valid(sample_valid), .sample_ready(sample_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_out(input logic [7:0] raw);
        if (!DARK) return raw;
        return (raw > DARK_LVL) ? raw - DARK_LVL : 8'd0;
    endfunction

    // Starts at the first observation point of a settle phase; ends at the entry of the next phase.
    task automatic phase(input string tag, input int settle_len, input logic e_li, input logic e_lr,
                         input logic [6:0] e_dc, input logic [3:0] e_pga,
                         input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                         input logic [7:0] v3, input int gap);
        int ok = 0;
        logic [7:0] vals [4];
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < settle_len; i++) begin
            if (led_ir === e_li && led_red === e_lr && dc_comp === e_dc &&
                pga_gain === e_pga && sample_valid === 1'b0) ok++;
            adc = 8'hFF; adc_valid = 1'b1;
            tick();
        end
        check({tag, "_settle_hold"}, ok, settle_len);
        check({tag, "_acq_led"}, {led_ir, led_red}, {e_li, e_lr});
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    adc = 8'hFF; adc_valid = 1'b0;
                    tick();
                end
            end
            adc = vals[i]; adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic pair(input string tag, input logic [7:0] i0, input logic [7:0] i1,
                        input logic [7:0] i2, input logic [7:0] i3, input logic [7:0] r0,
                        input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
                        input int gap);
        phase({tag, "_ir"}, 16, 1'b1, 1'b0, e_dc_ir, e_pga_ir, i0, i1, i2, i3, gap);
        phase({tag, "_red"}, 16, 1'b0, 1'b1, e_dc_red, e_pga_red, r0, r1, r2, r3, gap);
        if (DARK)
            phase({tag, "_dark"}, 8, 1'b0, 1'b0, e_dc_ir, e_pga_ir,
                  DARK_LVL, DARK_LVL, DARK_LVL, DARK_LVL, gap);
    endtask

    task automatic check_present(input string tag, input logic [7:0] e_ir, input logic [7:0] e_red,
                                 input logic e_cir, input logic e_cred);
        check({tag, "_valid"}, sample_valid, 1'b1);
        check({tag, "_ir_sample"}, ir_sample, exp_out(e_ir));
        check({tag, "_red_sample"}, red_sample, exp_out(e_red));
        check({tag, "_clip"}, {clip_ir, clip_red}, {e_cir, e_cred});
        check({tag, "_leds_off"}, {led_ir, led_red}, 2'b00);
    endtask

    task automatic transfer(input string tag);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        check({tag, "_valid_drop"}, sample_valid, 1'b0);
        check({tag, "_reenter_ir"}, {led_ir, dc_comp}, {1'b1, e_dc_ir});
    endtask

    initial begin
        int ok;
        logic [7:0] snap_ir, snap_red;
        rst_n = 1'b0; run = 1'b0; adc = 8'd0; adc_valid = 1'b0; sample_ready = 1'b0;
        dc_ir = 7'd40; pga_ir = 4'd5; dc_red = 7'd20; pga_red = 4'd9;
        tick();
        tick();
        check("rst_leds", {led_ir, led_red}, 2'b00);
        check("rst_dc", dc_comp, 7'd64);
        check("rst_pga", pga_gain, 4'd0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_samples", {ir_sample, red_sample, clip_ir, clip_red}, 18'd0);

        // Settings are latched once; later input changes must not reach the outputs.
        e_dc_ir = 7'd40; e_pga_ir = 4'd5; e_dc_red = 7'd20; e_pga_red = 4'd9;
        rst_n = 1'b1; run = 1'b1;
        tick();
        dc_ir = 7'd99; pga_ir = 4'd1; dc_red = 7'd98; pga_red = 4'd2;

        pair("p1", 8'd100, 8'd102, 8'd104, 8'd106, 8'd50, 8'd50, 8'd50, 8'd50, 0);
        check_present("p1", 8'd103, 8'd50, 1'b0, 1'b0);

        snap_ir = ir_sample; snap_red = red_sample;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_valid === 1'b1 && ir_sample === snap_ir && red_sample === snap_red &&
                {led_ir, led_red} === 2'b00 && dc_comp === 7'd64) ok++;
            tick();
        end
        check("bp_hold", ok, 10);
        transfer("bp");

        pair("p2", 8'd10, 8'd20, 8'd30, 8'd40, 8'hFF, 8'd1, 8'd2, 8'd3, 0);
        check_present("p2", 8'd25, 8'd65, 1'b0, 1'b1);
        transfer("p2");

        pair("p3", 8'd8, 8'd9, 8'd10, 8'd11, 8'd200, 8'd201, 8'd202, 8'd203, 2);
        check_present("p3", 8'd9, 8'd201, 1'b0, 1'b0);
        transfer("p3");

        // Abort in the middle of ACQ_RED.
        phase("p4_ir", 16, 1'b1, 1'b0, e_dc_ir, e_pga_ir, 8'd1, 8'd1, 8'd1, 8'd1, 0);
        for (int i = 0; i < 16; i++) tick();
        check("p4_acq_red", {led_red, dc_comp}, {1'b1, e_dc_red});
        adc = 8'd60; adc_valid = 1'b1;
        tick();
        tick();
        adc_valid = 1'b0; run = 1'b0;
        tick();
        check("abort_leds", {led_ir, led_red}, 2'b00);
        check("abort_dc", dc_comp, 7'd64);
        check("abort_pga", pga_gain, 4'd0);
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (sample_valid === 1'b0) ok++;
            tick();
        end
        check("abort_no_valid", ok, 4);

        dc_ir = 7'd33; pga_ir = 4'd3; dc_red = 7'd11; pga_red = 4'd2;
        e_dc_ir = 7'd33; e_pga_ir = 4'd3; e_dc_red = 7'd11; e_pga_red = 4'd2;
        run = 1'b1;
        tick();
        check("relatch_ir", {led_ir, dc_comp, pga_gain}, {1'b1, 7'd33, 4'd3});
        pair("p5", 8'd4, 8'd4, 8'd4, 8'd4, 8'd60, 8'd61, 8'd62, 8'd63, 0);
        check_present("p5", 8'd4, 8'd61, 1'b0, 1'b0);

        // Reset while a pair is pending overrides the handshake.
        rst_n = 1'b0;
        tick();
        check("midrst_valid", sample_valid, 1'b0);
        check("midrst_state", {dc_comp, ir_sample, red_sample}, {7'd64, 8'd0, 8'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
